// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit:
// operation encodings, FSM states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Counter wide enough for any sane latency setting.
    localparam int CNT_W = 16;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair. One 64-bit write bus: [63:32] feeds HI,
// [31:0] feeds LO; we_hi/we_lo select which half is written.
// Ports: clk, reset (sync, active-high), wdata, we_hi, we_lo, hi, lo.
module hilo_regs
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] wdata,
    input  logic        we_hi,
    input  logic        we_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (we_hi) hi <= wdata[63:32];
            if (we_lo) lo <= wdata[31:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Ports: clk, reset, a, b, md_op, start in; busy, hi, lo out.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  md_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q;
    logic [31:0]        a_q, b_q;
    logic               accept;

    logic [63:0]        res;
    logic               res_ok;
    logic [63:0]        wdata;
    logic               we_hi, we_lo;

    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sq, sr;
    logic [31:0]        uq, ur;

    // Result datapath works only on latched operands, so input
    // changes while busy cannot disturb the committed value.
    always_comb begin
        sa64 = {{32{a_q[31]}}, a_q};
        sb64 = {{32{b_q[31]}}, b_q};
        sq   = '0;
        sr   = '0;
        uq   = '0;
        ur   = '0;
        if (b_q != '0) begin
            sq = $signed(a_q) / $signed(b_q);
            sr = $signed(a_q) % $signed(b_q);
            uq = a_q / b_q;
            ur = a_q % b_q;
        end
    end

    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        unique case (op_q)
            OP_MULT:  res = sa64 * sb64;
            OP_MULTU: res = {32'd0, a_q} * {32'd0, b_q};
            OP_DIV: begin
                if (b_q == '0) begin
                    res_ok = 1'b0;
                end else if (a_q == 32'h8000_0000 &&
                             b_q == 32'hFFFF_FFFF) begin
                    // Overflow case: quotient wraps, remainder zero.
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    res = {sr, sq};
                end
            end
            OP_DIVU: begin
                if (b_q == '0) res_ok = 1'b0;
                else           res = {ur, uq};
            end
            default: res_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        we_hi   = 1'b0;
        we_lo   = 1'b0;
        wdata   = {a, a};
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (md_op_e'(md_op))
                        OP_MULT, OP_MULTU: begin
                            accept  = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept  = 1'b1;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_MTHI: we_hi = 1'b1;
                        OP_MTLO: we_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Final busy cycle: commit and return to idle.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    wdata   = res;
                    we_hi   = res_ok;
                    we_lo   = res_ok;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q <= md_op_e'(md_op);
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign busy = (state_q == ST_BUSY);

    hilo_regs u_hilo (
        .clk   (clk),
        .reset (reset),
        .wdata (wdata),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: time-based reference model
// compared every cycle, plus directed literal expectations.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [2:0]  md_op;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .md_op (md_op),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: an accepted operation's result is computed
    // at once and scheduled to appear at edge (accept + latency).
    int          cyc = 0;
    bit          mvalid = 0;
    logic [31:0] m_hi, m_lo;
    bit          pend = 0;
    int          done_cyc;
    bit          p_wr;
    logic [31:0] p_hi, p_lo;

    always @(posedge clk) begin
        longint          sa, sb, q, r;
        longint unsigned up;
        cyc++;
        if (reset) begin
            mvalid = 1;
            m_hi = 0;
            m_lo = 0;
            pend = 0;
        end else if (pend) begin
            if (cyc == done_cyc) begin
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                pend = 0;
            end
        end else if (start) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p_wr = 1;
            case (md_op)
                3'd1, 3'd2: begin
                    if (md_op == 3'd1) up = sa * sb;
                    else up = 64'(a) * 64'(b);
                    p_hi = up[63:32];
                    p_lo = up[31:0];
                    pend = 1;
                    done_cyc = cyc + 5;
                end
                3'd3: begin
                    if (b == 0) p_wr = 0;
                    else begin
                        q = sa / sb;
                        r = sa % sb;
                        p_lo = q[31:0];
                        p_hi = r[31:0];
                    end
                    pend = 1;
                    done_cyc = cyc + 10;
                end
                3'd4: begin
                    if (b == 0) p_wr = 0;
                    else begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                    pend = 1;
                    done_cyc = cyc + 10;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #2;
        if (mvalid) begin
            chk("model_busy", {31'd0, busy}, {31'd0, pend});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n < 100) passed++;
        else $display("FAIL wait_idle: busy stuck after %0d cycles", n);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd0);
        wait_idle(n);
        chk("divz_cycles", n, 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        @(negedge clk);
        start = 1'b1;
        md_op = 3'd5;
        a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        md_op = 3'd6;
        a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtx_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        issue(3'd1, 32'h0001_0000, 32'h0003_0001);
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd6;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        chk("ign_hi", hi, 32'h0000_0003);
        chk("ign_lo", lo, 32'h0001_0000);

        issue(3'd0, 32'h5555_5555, 32'd1);
        chk("nop0_busy", {31'd0, busy}, 32'd0);
        issue(3'd7, 32'h5555_5555, 32'd1);
        chk("nop7_busy", {31'd0, busy}, 32'd0);
        chk("nop_lo", lo, 32'h0001_0000);

        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstb_busy", {31'd0, busy}, 32'd0);
        chk("rstb_hi", hi, 32'd0);
        chk("rstb_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("rstb_late_lo", lo, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd5;
        a = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_pri_hi", hi, 32'd0);

        issue(3'd2, 32'h0000_0010, 32'h1000_0001);
        wait_idle(n);
        chk("post_rst_cycles", n, 32'd5);
        chk("post_rst_hi", hi, 32'h0000_0001);
        chk("post_rst_lo", lo, 32'h0000_0010);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
